// File: rtl/ntt_pkg.sv
// Shared NTT constants and types.
//   Q, LOG_Q, LOG_N : modulus, residue width, log2 transform length
//   BARRETT_K       : floor(2^(2*LOG_Q) / Q), Barrett reciprocal
//   ROOT_TBL        : [0][s] primitive 2^(s+1)-th root of unity mod Q, [1][s] its inverse
//   root_lookup     : table read that returns 1 for out-of-range stage numbers
package ntt_pkg;

    localparam int Q         = 7681;
    localparam int LOG_Q     = 13;
    localparam int LOG_N     = 5;
    localparam int BARRETT_K = (1 << (2 * LOG_Q)) / Q;

    typedef logic [LOG_Q-1:0] coeff_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } tfu_state_t;

    // Derived from generator 17: w32 = 17^240 = 5235; each lower stage is the
    // square of the next one up, so stage 0 lands on Q-1.
    localparam coeff_t ROOT_TBL [2][LOG_N] = '{
        '{13'd7680, 13'd3383, 13'd1925, 13'd7098, 13'd5235},
        '{13'd7680, 13'd4298, 13'd1213, 13'd7154, 13'd6315}
    };

    function automatic coeff_t root_lookup(input logic inv, input logic [3:0] idx);
        coeff_t r;
        r = coeff_t'(1);
        for (int s = 0; s < LOG_N; s++) begin
            if (idx == 4'(s)) r = ROOT_TBL[inv][s];
        end
        return r;
    endfunction

endpackage

// File: rtl/barrett_modmul.sv
// Combinational modular multiply y = a*b mod Q using Barrett reduction.
//   a, b : residues in [0, Q-1]
//   y    : product residue in [0, Q-1]
// Shared with the butterfly datapath.
module barrett_modmul #(
    parameter int Q     = 7681,
    parameter int LOG_Q = 13
) (
    input  logic [LOG_Q-1:0] a,
    input  logic [LOG_Q-1:0] b,
    output logic [LOG_Q-1:0] y
);
    localparam int PW = 2 * LOG_Q;         // full product width
    localparam int KW = LOG_Q + 1;         // width of K, quotient estimate and r
    localparam int XW = PW + KW;           // p * K width
    localparam int K  = (1 << PW) / Q;

    logic [PW-1:0] p;
    logic [XW-1:0] pk;
    logic [KW-1:0] t;
    logic [PW-1:0] tq;
    logic [KW-1:0] r;

    always_comb begin
        p  = PW'(a) * PW'(b);
        pk = XW'(p) * XW'(K);
        // Quotient estimate is at most one short, so r lands in [0, 2Q).
        t  = pk[XW-1:PW];
        tq = PW'(t) * PW'(Q);
        r  = KW'(p - tq);
        y  = (r >= KW'(Q)) ? LOG_Q'(r - KW'(Q)) : LOG_Q'(r);
    end

endmodule

// File: rtl/twiddle_factor_unit.sv
// Running twiddle factor generator that follows the NTT address unit.
//   clk, rst_n      : clock, synchronous active-low reset
//   ntt_start       : start pulse, latches inverse
//   inverse         : select inverse-root table for this run
//   update_m        : new stage, omega_m := table[index], omega := 1
//   update_omega    : omega := omega * omega_m mod Q
//   index           : stage number
//   run_loop_i      : address unit loop-active; its falling edge ends the run
//   omega_o         : current twiddle, zero-extended
//   omega_valid_o   : a stage root is loaded in this run
//   busy_o          : run in progress
//   err_o           : sticky, stage index out of range was seen
module twiddle_factor_unit
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LOG_N      = ntt_pkg::LOG_N,
    parameter int Q          = ntt_pkg::Q,
    parameter int LOG_Q      = ntt_pkg::LOG_Q
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ntt_start,
    input  logic                  inverse,
    input  logic                  update_m,
    input  logic                  update_omega,
    input  logic [3:0]            index,
    input  logic                  run_loop_i,
    output logic [DATA_WIDTH-1:0] omega_o,
    output logic                  omega_valid_o,
    output logic                  busy_o,
    output logic                  err_o
);
    tfu_state_t       state;
    logic             inv_q;
    logic             run_prev;
    logic             run_fall;
    logic [LOG_Q-1:0] omega;
    logic [LOG_Q-1:0] omega_m;
    logic [LOG_Q-1:0] product;

    barrett_modmul #(.Q(Q), .LOG_Q(LOG_Q)) u_modmul (
        .a (omega),
        .b (omega_m),
        .y (product)
    );

    assign run_fall = run_prev & ~run_loop_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            inv_q         <= 1'b0;
            run_prev      <= 1'b0;
            omega         <= LOG_Q'(1);
            omega_m       <= LOG_Q'(1);
            omega_valid_o <= 1'b0;
            busy_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            run_prev <= run_loop_i;
            case (state)
                S_IDLE: begin
                    if (ntt_start) begin
                        state         <= S_ACTIVE;
                        busy_o        <= 1'b1;
                        inv_q         <= inverse;
                        err_o         <= 1'b0;
                        omega         <= LOG_Q'(1);
                        omega_valid_o <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (run_fall) begin
                        state         <= S_IDLE;
                        busy_o        <= 1'b0;
                        omega         <= LOG_Q'(1);
                        omega_valid_o <= 1'b0;
                    end else if (update_m) begin
                        // Stage boundary: the new root wins over a coincident update_omega.
                        omega_m       <= LOG_Q'(root_lookup(inv_q, index));
                        omega         <= LOG_Q'(1);
                        omega_valid_o <= 1'b1;
                        if (int'(index) >= LOG_N) err_o <= 1'b1;
                    end else if (update_omega) begin
                        omega <= product;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign omega_o = DATA_WIDTH'(omega);

endmodule

// File: doc/twiddle_factor_unit.md
Name: twiddle_factor_unit

Overview:
- Downstream companion of the NTT address unit.
- Consumes its update_m, update_omega, index and run_loop strobes and maintains the running twiddle factor omega used by the butterfly each cycle.
- Per stage: loads the stage root omega_m from a constant table (forward or inverse), resets omega to 1, then multiplies omega by omega_m modulo Q on each update_omega.
- Result is registered so omega_o is valid the cycle the delayed addresses reach the butterfly.

Parameters:
DATA_WIDTH, 32, width of omega_o (zero-extended coefficient)
LOG_N, 5, log2 of transform length; stage count = LOG_N (index 0..LOG_N-1)
Q, 7681, prime modulus
LOG_Q, 13, bit width of residues mod Q

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ntt_start  in  1  one-cycle start pulse; latches inverse
inverse  in  1  1 = use inverse-root table (sampled only with ntt_start)
update_m  in  1  new stage: load omega_m from table[index], omega := 1
update_omega  in  1  omega := omega * omega_m mod Q
index  in  4  stage number from address unit
run_loop_i  in  1  address unit loop-active flag
omega_o  out  DATA_WIDTH  current twiddle, bits above LOG_Q zero
omega_valid_o  out  1  high while ACTIVE and a stage root is loaded
busy_o  out  1  high in ACTIVE
err_o  out  1  sticky: update_m seen with index >= LOG_N

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is synchronous, active-low, sampled only on posedge clk.
- Reset values: omega=1, omega_m=1, omega_o=1, omega_valid_o=0, busy_o=0, err_o=0, inv_q=0, state=IDLE.
- Reset asserted mid-operation: all of the above are restored on the next edge. No partial product survives.
- FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE on ntt_start. inv_q<=inverse, err_o<=0, omega<=1, valid<=0.
  - ACTIVE -> IDLE on the run_loop_i falling edge (registered prev=1, now=0). omega<=1, valid<=0.
  - ntt_start while ACTIVE is ignored.
- Strobes are acted on only in ACTIVE. In IDLE, update_m and update_omega are ignored.
- update_m (priority over update_omega when both are high in the same cycle, as happens at stage boundaries):
  - omega_m<=ROOT_TBL[inv_q][index]; omega<=1; omega_valid_o<=1.
  - If index>=LOG_N: omega_m<=1 and err_o<=1 (sticky until the next ntt_start or reset).
- update_omega alone: omega<=modmul(omega, omega_m). Exactly one-cycle latency: the product is visible on omega_o the cycle after the strobe.
- Neither strobe: omega holds.
- omega_o = zero-extended omega register. No combinational path from inputs to outputs.
- modmul(a,b), inputs in [0,Q-1]:
  - p=a*b (2*LOG_Q bits).
  - t=(p*BARRETT_K)>>(2*LOG_Q), with BARRETT_K=floor(2^(2*LOG_Q)/Q) (8736 for Q=7681).
  - r=p-t*Q, range [0,2Q).
  - One conditional subtract of Q.
  - Output is always in [0,Q-1]. Intermediate widths are sized so no overflow occurs.
- ROOT_TBL[0][s] is a primitive 2^(s+1)-th root of unity mod Q. ROOT_TBL[1][s] is its inverse. Entry s=0 is Q-1 for both.

Decomposition:
- Package ntt_pkg:
  - Q, LOG_Q, BARRETT_K
  - ROOT_TBL (2 x LOG_N array of LOG_Q-bit constants)
  - coefficient typedef coeff_t (logic [LOG_Q-1:0])
  - FSM enum
- One sub-module: barrett_modmul (purely combinational a,b -> a*b mod Q). It is reused by the butterfly unit.

Test Plan:
- Reset then ntt_start with inverse=0, update_m at index=0 -> next cycle omega_o=1, omega_valid_o=1, busy_o=1. Then update_omega -> omega_o=7680. Then update_omega again -> omega_o=1.
- Same-cycle update_m and update_omega at index=1 after omega=7680 -> omega_o=1 and omega_m=ROOT_TBL[0][1] (update_m wins). Following update_omega -> ROOT_TBL[0][1].
- Modmul boundaries via barrett_modmul directly: (7680,7680)->1, (7680,7679)->2, (0,7680)->0, (1,7680)->7680.
- Forward run, then inverse run with inverse=1: after stage s load plus one update, forward value * inverse value mod Q = 1 for s=0..4.
- update_m with index=5 -> err_o=1 and omega_o stays 1 after subsequent updates. The next ntt_start clears err_o.
- rst_n low for one cycle mid-stage with omega=7680 -> next cycle omega_o=1, busy_o=0, valid=0. A run_loop_i falling edge in ACTIVE returns to IDLE, and strobes there are ignored.
